// File: rtl/alu_seq.sv
// ============================================================================
// Module   : alu_seq
// Brief    : Sequential ALU with A/B/pass operand registers, start/done
//            handshake and an iterative one-bit-per-cycle shifter.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] readd_a_i,
  input  logic [WIDTH-1:0] readd_b_i,
  input  logic [WIDTH-1:0] readd_pass_i,
  input  logic             readin_a_i,
  input  logic             readin_b_i,
  input  logic             readin_pass_i,
  input  logic [2:0]       op_i,
  input  logic             start_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic [WIDTH-1:0] pass_o,
  output logic             zero_o,
  output logic             carry_o
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SLT = 3'd5;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, pass_q, pass_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [SHW-1:0]   count_q, count_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] result_q, result_d, pass_out_q, pass_out_d;
  logic             zero_q, zero_d, carry_q, carry_d;
  logic             busy_q, busy_d, done_q, done_d;

  logic [WIDTH:0]   w_sum, w_diff;
  logic [WIDTH-1:0] w_alu_res, w_work_next;
  logic             w_alu_carry;
  logic [SHW-1:0]   w_shamt;

  assign w_sum   = {1'b0, a_q} + {1'b0, b_q};
  assign w_diff  = {1'b0, a_q} - {1'b0, b_q};
  assign w_shamt = b_q[SHW-1:0];
  assign w_work_next = dir_q ? (work_q >> 1) : (work_q << 1);

  // Shift opcodes only reach this path with a zero amount, so they pass a through.
  always_comb begin
    w_alu_res   = a_q;
    w_alu_carry = 1'b0;
    case (op_i)
      OP_ADD: begin
        w_alu_res   = w_sum[WIDTH-1:0];
        w_alu_carry = w_sum[WIDTH];
      end
      OP_SUB: begin
        w_alu_res   = w_diff[WIDTH-1:0];
        w_alu_carry = ~w_diff[WIDTH];
      end
      OP_AND:  w_alu_res = a_q & b_q;
      OP_OR:   w_alu_res = a_q | b_q;
      OP_XOR:  w_alu_res = a_q ^ b_q;
      OP_SLT:  w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      default: w_alu_res = a_q;
    endcase
  end

  always_comb begin
    a_d        = readin_a_i    ? readd_a_i    : a_q;
    b_d        = readin_b_i    ? readd_b_i    : b_q;
    pass_d     = readin_pass_i ? readd_pass_i : pass_q;
    state_d    = state_q;
    work_d     = work_q;
    count_d    = count_q;
    dir_d      = dir_q;
    result_d   = result_q;
    pass_out_d = pass_out_q;
    zero_d     = zero_q;
    carry_d    = carry_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          pass_out_d = pass_q;
          if (op_i[2:1] == 2'b11 && w_shamt != '0) begin
            work_d  = a_q;
            count_d = w_shamt;
            dir_d   = op_i[0];
            state_d = ST_SHIFT;
            busy_d  = 1'b1;
          end else begin
            result_d = w_alu_res;
            zero_d   = (w_alu_res == '0);
            carry_d  = w_alu_carry;
            done_d   = 1'b1;
          end
        end
      end
      ST_SHIFT: begin
        work_d  = w_work_next;
        count_d = count_q - SHW'(1);
        if (count_q == SHW'(1)) begin
          result_d = w_work_next;
          zero_d   = (w_work_next == '0);
          carry_d  = 1'b0;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      pass_q     <= '0;
      work_q     <= '0;
      count_q    <= '0;
      dir_q      <= 1'b0;
      result_q   <= '0;
      pass_out_q <= '0;
      zero_q     <= 1'b0;
      carry_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      pass_q     <= pass_d;
      work_q     <= work_d;
      count_q    <= count_d;
      dir_q      <= dir_d;
      result_q   <= result_d;
      pass_out_q <= pass_out_d;
      zero_q     <= zero_d;
      carry_q    <= carry_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign result_o = result_q;
  assign pass_o   = pass_out_q;
  assign zero_o   = zero_q;
  assign carry_o  = carry_q;

endmodule

`default_nettype wire
